// File: rtl/load_store_unit_if.sv
// Request/response and data_memory bus bundle for the load/store unit.
//   slave  : load_store_unit view (receives requests, drives the memory bus)
//   master : requester/memory view (drives requests and read data)
// Signals:
//   req_valid/req_ready      request handshake
//   req_we/req_size          store enable, access size (00 byte, 01 half, 10 word)
//   req_unsigned             load zero-extension select
//   req_addr/req_wdata       byte address, right-aligned store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata               extended load data
//   resp_misaligned          access rejected
//   mem_read/mem_write       data_memory strobes
//   mem_addr                 word-aligned memory address
//   mem_wdata/mem_rdata      memory write and read data
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_misaligned;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-only data_memory.
// Adds byte/halfword access: sub-word stores are read-modify-write, sub-word
// loads are sign- or zero-extended. Misaligned accesses are rejected without
// any memory traffic.
// Ports:
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   load_store_unit_if.slave (request handshake, response, memory bus)
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP, ERR} state_t;

  state_t state, state_nxt;

  logic                  ready_en;
  logic                  accept;
  logic                  misaligned;
  logic                  we_p0;
  logic [1:0]            size_p0;
  logic                  uns_p0;
  logic [1:0]            lane_p0;
  logic [15:0]           wdata_p0;
  logic [31:0]           rdata_p1;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [31:0]           mem_wdata_r;

  // Select the addressed byte/half lane and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext;
    case (lane)
      2'd0:    b_s = word[7:0];
      2'd1:    b_s = word[15:8];
      2'd2:    b_s = word[23:16];
      default: b_s = word[31:24];
    endcase
    h_s = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   ext = uns ? 32'($unsigned(b_s)) : 32'(b_s);
      2'b01:   ext = uns ? 32'($unsigned(h_s)) : 32'(h_s);
      default: ext = word;
    endcase
    return ext;
  endfunction

  // Replace the target byte/half lanes of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] m;
    m = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      m[31:16] = wd;
    end else begin
      m[15:0] = wd;
    end
    return m;
  endfunction

  always_comb begin
    case (bus.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // ready_en holds req_ready low until the first edge after reset release.
  assign bus.req_ready = (state == IDLE) && ready_en;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)                             state_nxt = ERR;
          else if (bus.req_we && bus.req_size == 2'b10) state_nxt = WR;
          else                                        state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = we_p0 ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request fields latched at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      size_p0  <= bus.req_size;
      uns_p0   <= bus.req_unsigned;
      lane_p0  <= bus.req_addr[1:0];
      wdata_p0 <= bus.req_wdata[15:0];
    end
  end

  // Stage p1: memory word captured at the end of CAP, so both combinational
  // and one-cycle registered memories are covered.
  always_ff @(posedge clk) begin
    if (state == CAP) rdata_p1 <= bus.mem_rdata;
  end

  // Memory-facing address/data registers hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      if (accept && !misaligned) begin
        mem_addr_r <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
        if (bus.req_we && bus.req_size == 2'b10) mem_wdata_r <= bus.req_wdata;
      end
      if (state == CAP && we_p0)
        mem_wdata_r <= store_merge(bus.mem_rdata, wdata_p0, size_p0, lane_p0);
    end
  end

  always_comb begin
    bus.mem_read        = (state == RD) || (state == CAP);
    bus.mem_write       = (state == WR);
    bus.resp_valid      = (state == RESP) || (state == ERR);
    bus.resp_misaligned = (state == ERR);
    bus.resp_rdata      = '0;
    if (state == RESP && !we_p0)
      bus.resp_rdata = load_extend(rdata_p1, size_p0, lane_p0, uns_p0);
  end

  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule
